// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-controller front end: beat codes,
// flag-update select encodings, memory-opcode range and the flag bundle.
// Optional feature macro used by importers: SINGLE_STEP_EN.
package cpu_pkg;

  localparam int unsigned IW     = 16;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned SST_W  = 2;

  typedef enum logic [BEAT_W-1:0] {
    BEAT_FETCH_A = 3'b000,
    BEAT_FETCH_D = 3'b001,
    BEAT_EXEC    = 3'b011,
    BEAT_IDLE    = 3'b100,
    BEAT_MEM_A   = 3'b101,
    BEAT_MEM_D   = 3'b111
  } beat_e;

  localparam beat_e RESET_BEAT = BEAT_IDLE;

  typedef enum logic [SST_W-1:0] {
    SST_LOAD  = 2'b00,
    SST_SET_C = 2'b01,
    SST_CLR_C = 2'b10,
    SST_HOLD  = 2'b11
  } sst_e;

  localparam logic [OP_W-1:0] MEM_OP_LO = 8'h80;
  localparam logic [OP_W-1:0] MEM_OP_HI = 8'h83;

  typedef struct packed {
    logic c;
    logic z;
    logic v;
    logic s;
  } flags_t;

  // True for opcodes that need the two-beat memory phase.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op >= MEM_OP_LO) && (op <= MEM_OP_HI);
  endfunction

endpackage

// File: rtl/cpu_flag_reg.sv
// C/Z/V/S flag register. Updates only when en (execute beat) is high and
// hold is low, according to the controller's flag-update select.
// Ports: clk, reset (sync, active high), hold, en, sst[1:0], alu_flags in;
//        flags out (registered).
module cpu_flag_reg
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             en,
  input  logic [SST_W-1:0] sst,
  input  flags_t           alu_flags,
  output flags_t           flags
);

  flags_t flags_d;

  // Next-flag decode from sst.
  always_comb begin
    flags_d = flags;
    if (en && !hold) begin
      case (sst_e'(sst))
        SST_LOAD:  flags_d = alu_flags;
        SST_SET_C: flags_d.c = 1'b1;
        SST_CLR_C: flags_d.c = 1'b0;
        default:   flags_d = flags;
      endcase
    end
  end

  // Flag storage.
  always_ff @(posedge clk) begin
    if (reset) flags <= '0;
    else       flags <= flags_d;
  end

endmodule

// File: rtl/cpu_beat_sequencer.sv
// Beat sequencer for the instruction controller: produces the beat code,
// holds the instruction register and the C/Z/V/S flags.
// Ports: clk, reset (sync, active high), hold, mem_data[15:0], sst[1:0],
//        alu_c/z/v/s, step in; timer[2:0], instruction[15:0], c/z/v/s out.
// Optional macro SINGLE_STEP_EN: park in the idle beat after each
// instruction until a step pulse is sampled.
module cpu_beat_sequencer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [IW-1:0]     mem_data,
  input  logic [SST_W-1:0]  sst,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_s,
  input  logic              step,
  output logic [BEAT_W-1:0] timer,
  output logic [IW-1:0]     instruction,
  output logic              c,
  output logic              z,
  output logic              v,
  output logic              s
);

  beat_e  state_q;
  beat_e  state_d;
  logic   ir_load_c;
  logic   step_go_c;
  beat_e  after_instr_c;
  flags_t flags;

`ifdef SINGLE_STEP_EN
  assign step_go_c     = step;
  assign after_instr_c = BEAT_IDLE;
`else
  logic step_unused;
  assign step_unused   = step;
  assign step_go_c     = 1'b1;
  assign after_instr_c = BEAT_FETCH_A;
`endif

  // Beat state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_BEAT;
    else       state_q <= state_d;
  end

  // Next beat; the fetch-data decision looks at the bus, not the old IR.
  always_comb begin
    state_d   = state_q;
    ir_load_c = 1'b0;
    if (!hold) begin
      case (state_q)
        BEAT_IDLE:    state_d = step_go_c ? BEAT_FETCH_A : BEAT_IDLE;
        BEAT_FETCH_A: state_d = BEAT_FETCH_D;
        BEAT_FETCH_D: begin
          ir_load_c = 1'b1;
          state_d   = is_mem_op(mem_data[IW-1:IW-OP_W]) ? BEAT_MEM_A : BEAT_EXEC;
        end
        BEAT_EXEC:    state_d = after_instr_c;
        BEAT_MEM_A:   state_d = BEAT_MEM_D;
        BEAT_MEM_D:   state_d = after_instr_c;
        default:      state_d = BEAT_IDLE;
      endcase
    end
  end

  // Instruction register.
  always_ff @(posedge clk) begin
    if (reset)          instruction <= '0;
    else if (ir_load_c) instruction <= mem_data;
  end

  cpu_flag_reg u_flag_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (hold),
    .en        (state_q == BEAT_EXEC),
    .sst       (sst),
    .alu_flags ('{c: alu_c, z: alu_z, v: alu_v, s: alu_s}),
    .flags     (flags)
  );

  assign timer = BEAT_W'(state_q);
  assign c     = flags.c;
  assign z     = flags.z;
  assign v     = flags.v;
  assign s     = flags.s;

endmodule

// File: tb/tb_cpu_beat_sequencer.sv
// Self-checking bench for cpu_beat_sequencer: instruction-level model plus
// directed literal checks and a randomised stretch.
module tb_cpu_beat_sequencer;

  logic        clk = 1'b0;
  logic        reset, hold, step;
  logic [15:0] mem_data;
  logic [1:0]  sst;
  logic        alu_c, alu_z, alu_v, alu_s;
  logic [2:0]  timer;
  logic [15:0] instruction;
  logic        c, z, v, s;

  int tests  = 0;
  int failed = 0;

  cpu_beat_sequencer dut (
    .clk(clk), .reset(reset), .hold(hold), .mem_data(mem_data), .sst(sst),
    .alu_c(alu_c), .alu_z(alu_z), .alu_v(alu_v), .alu_s(alu_s), .step(step),
    .timer(timer), .instruction(instruction), .c(c), .z(z), .v(v), .s(s)
  );

  always #5 clk = ~clk;

`ifdef SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  // Instruction-level model: idle flag, position within instruction,
  // memory-class flag, IR and flags {c,z,v,s}.
  bit          m_idle = 1'b1;
  int          m_pos  = 0;
  bit          m_mem  = 1'b0;
  logic [15:0] m_ir   = '0;
  logic [3:0]  m_f    = '0;
  bit          started = 1'b0;

  function automatic logic [2:0] m_timer();
    if (m_idle) return 3'b100;
    case (m_pos)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return m_mem ? 3'b101 : 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit          n_idle, n_mem, done;
    int          n_pos;
    logic [15:0] n_ir;
    logic [3:0]  n_f;
    n_idle = m_idle; n_pos = m_pos; n_mem = m_mem; n_ir = m_ir; n_f = m_f;
    done = 1'b0;
    if (reset) begin
      n_idle = 1'b1; n_pos = 0; n_ir = '0; n_f = '0;
    end else if (!hold) begin
      if (m_idle) begin
        if (!SS || step) begin n_idle = 1'b0; n_pos = 0; end
      end else if (m_pos == 0) begin
        n_pos = 1;
      end else if (m_pos == 1) begin
        n_ir  = mem_data;
        n_mem = (mem_data[15:8] >= 8'h80) && (mem_data[15:8] <= 8'h83);
        n_pos = 2;
      end else if (m_pos == 2 && !m_mem) begin
        if (sst == 2'b00)      n_f = {alu_c, alu_z, alu_v, alu_s};
        else if (sst == 2'b01) n_f[3] = 1'b1;
        else if (sst == 2'b10) n_f[3] = 1'b0;
        done = 1'b1;
      end else if (m_pos == 2) begin
        n_pos = 3;
      end else begin
        done = 1'b1;
      end
      if (done) begin
        n_pos = 0;
        if (SS) n_idle = 1'b1;
      end
    end
    m_idle  <= n_idle;
    m_pos   <= n_pos;
    m_mem   <= n_mem;
    m_ir    <= n_ir;
    m_f     <= n_f;
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("model_timer", 16'(timer), 16'(m_timer()));
      chk("model_ir", instruction, m_ir);
      chk("model_flags", 16'({c, z, v, s}), 16'(m_f));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_alu(input logic [3:0] f);
    {alu_c, alu_z, alu_v, alu_s} = f;
  endtask

  logic [7:0] ops [5] = '{8'h7F, 8'h80, 8'h83, 8'h84, 8'hFF};
  logic [7:0] rops [7] = '{8'h12, 8'h7F, 8'h80, 8'h81, 8'h83, 8'h84, 8'hFF};

  initial begin
    reset = 1'b1; hold = 1'b0; step = 1'b0; mem_data = 16'h0012; sst = 2'b11;
    set_alu(4'b0000);
    @(negedge clk);
    tick();
    chk("rst_timer", 16'(timer), 16'h0004);
    chk("rst_ir", instruction, 16'h0000);
    chk("rst_flags", 16'({c, z, v, s}), 16'h0000);
    reset = 1'b0;
`ifndef SINGLE_STEP_EN
    tick(); chk("seq_fa", 16'(timer), 16'h0000);
    tick(); chk("seq_fd", 16'(timer), 16'h0001);
    tick(); chk("seq_ex", 16'(timer), 16'h0003);
    chk("ir_0012", instruction, 16'h0012);
    sst = 2'b00; set_alu(4'b1011);
    tick(); chk("seq_fa2", 16'(timer), 16'h0000);
    chk("flags_load", 16'({c, z, v, s}), 16'h000B);
    sst = 2'b00; set_alu(4'b0000);
    tick(); chk("flags_beat000", 16'({c, z, v, s}), 16'h000B);
    sst = 2'b10;
    tick(); chk("flags_pre_clr", 16'({c, z, v, s}), 16'h000B);
    tick(); chk("flags_clr_c", 16'({c, z, v, s}), 16'h0003);
    sst = 2'b11; mem_data = 16'h8234;
    tick(); chk("mem_fd", 16'(timer), 16'h0001);
    tick(); chk("mem_ma", 16'(timer), 16'h0005);
    chk("ir_8234", instruction, 16'h8234);
    tick(); chk("mem_md", 16'(timer), 16'h0007);
    tick(); chk("mem_fa", 16'(timer), 16'h0000);
    mem_data = 16'h0001;
    tick(); chk("hold_fd", 16'(timer), 16'h0001);
    hold = 1'b1;
    tick(); chk("hold1", 16'(timer), 16'h0001);
    chk("hold_ir", instruction, 16'h8234);
    mem_data = 16'h8000;
    tick(); chk("hold2", 16'(timer), 16'h0001);
    tick(); chk("hold3", 16'(timer), 16'h0001);
    hold = 1'b0;
    tick(); chk("hold_rel_timer", 16'(timer), 16'h0005);
    chk("hold_rel_ir", instruction, 16'h8000);
    tick(); chk("pre_rst_md", 16'(timer), 16'h0007);
    reset = 1'b1;
    tick(); chk("rst_md_timer", 16'(timer), 16'h0004);
    chk("rst_md_ir", instruction, 16'h0000);
    chk("rst_md_flags", 16'({c, z, v, s}), 16'h0000);
    reset = 1'b0; mem_data = 16'h00AB;
    tick(); tick();
    tick(); chk("ex_ab", 16'(timer), 16'h0003);
    sst = 2'b00; set_alu(4'b1111);
    tick(); chk("flags_all", 16'({c, z, v, s}), 16'h000F);
    reset = 1'b1; hold = 1'b1;
    tick(); chk("rst_hold_timer", 16'(timer), 16'h0004);
    chk("rst_hold_ir", instruction, 16'h0000);
    chk("rst_hold_flags", 16'({c, z, v, s}), 16'h0000);
    reset = 1'b0; hold = 1'b0; sst = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_data = {ops[i], 8'h5A};
      tick();
      tick();
      chk("op_class", 16'(timer),
          ((ops[i] >= 8'h80) && (ops[i] <= 8'h83)) ? 16'h0005 : 16'h0003);
      chk("op_ir", instruction, {ops[i], 8'h5A});
      if ((ops[i] >= 8'h80) && (ops[i] <= 8'h83)) tick();
      tick();
    end
`else
    for (int i = 0; i < 5; i++) begin
      tick(); chk("ss_wait", 16'(timer), 16'h0004);
    end
    step = 1'b1;
    tick(); chk("ss_go", 16'(timer), 16'h0000);
    step = 1'b0;
    tick(); chk("ss_fd", 16'(timer), 16'h0001);
    step = 1'b1;
    tick(); chk("ss_ex", 16'(timer), 16'h0003);
    step = 1'b0;
    tick(); chk("ss_back_idle", 16'(timer), 16'h0004);
    tick(); chk("ss_no_queue", 16'(timer), 16'h0004);
    step = 1'b1;
    tick(); chk("ss_go2", 16'(timer), 16'h0000);
    step = 1'b0;
`endif
    // Randomised stretch, checked by the model every cycle.
    for (int k = 0; k < 400; k++) begin
      hold     = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 59) == 0);
      step     = ($urandom_range(0, 2) == 0);
      sst      = 2'($urandom_range(0, 3));
      set_alu(4'($urandom_range(0, 15)));
      mem_data = {rops[$urandom_range(0, 6)], 8'($urandom_range(0, 255))};
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
